// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register target
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - pad synchroniser with history flop and edge pulses
module i2c_sync_edge
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pad_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                  hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], pad_in};
        hist_d = sync_q[SYNC_DEPTH-1];
    end

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[SYNC_DEPTH-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - oversampled I2C target with auto-increment register file
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR  = 7'h2A,
    parameter int         NREGS = 16,
    localparam int        PW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic [PW-1:0] loc_addr,
    input  logic          loc_we,
    input  logic [7:0]    loc_wdata,
    output logic [7:0]    loc_rdata,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_index,
    output logic          busy
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge u_scl (
        .clk    (clk),
        .rst    (rst),
        .pad_in (scl_in),
        .level  (scl_s),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_sync_edge u_sda (
        .clk    (clk),
        .rst    (rst),
        .pad_in (sda_in),
        .level  (sda_s),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          phase_q, phase_d;
    logic          rw_q, rw_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [PW-1:0] wr_index_q, wr_index_d;
    logic [7:0]    loc_rdata_q, loc_rdata_d;
    logic [7:0]    regs_q [NREGS];
    logic [7:0]    regs_d [NREGS];

    logic          i2c_we;
    logic          start_det, stop_det;
    logic [7:0]    byte_in;
    logic [7:0]    rd_byte;
    logic [PW-1:0] ptr_inc;

    // SCL counts as high when it was high before this cycle, so a START/STOP
    // landing on the same clk as an SCL fall still wins over the data edge.
    assign start_det = sda_fall & (scl_s | scl_fall);
    assign stop_det  = sda_rise & (scl_s | scl_fall);
    assign byte_in   = {shift_q[6:0], sda_s};
    assign rd_byte   = regs_q[ptr_q];
    assign ptr_inc   = ptr_q + PW'(1);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        phase_d     = phase_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        i2c_we      = 1'b0;
        loc_rdata_d = regs_q[loc_addr];

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd7;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        phase_d   = 1'b0;
                        if (bit_cnt_q == 3'd0) begin
                            if (state_q == ST_ADDR) begin
                                if (byte_in[7:1] == ADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = byte_in[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = byte_in[PW-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                i2c_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_index_d  = ptr_q;
                                ptr_d       = ptr_inc;
                                state_d     = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // First SCL fall starts driving ACK, second fall ends the ACK bit.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d  = 1'b1;
                            sda_oe_d = ~ACK;
                        end else begin
                            phase_d   = 1'b0;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd7;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                shift_d  = rd_byte;
                                ptr_d    = ptr_inc;
                                sda_oe_d = ~rd_byte[7];
                                state_d  = ST_RDATA;
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q != 3'd0) begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = ST_RDATA_ACK;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == NACK) begin
                            state_d = ST_IGNORE;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        shift_d   = rd_byte;
                        ptr_d     = ptr_inc;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 3'd7;
                        phase_d   = 1'b0;
                        state_d   = ST_RDATA;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // The I2C write is applied last so it overrides a same-index local write.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (loc_we && loc_addr == PW'(i)) begin
                regs_d[i] = loc_wdata;
            end
            if (i2c_we && ptr_q == PW'(i)) begin
                regs_d[i] = byte_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            loc_rdata_q <= 8'h00;
            regs_q      <= '{default: 8'h00};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            phase_q     <= phase_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            loc_rdata_q <= loc_rdata_d;
            regs_q      <= regs_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign loc_rdata = loc_rdata_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - bus-level checks of i2c_slave_regs against a register-file model
module tb_i2c_slave_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       scl_in, sda_in, sda_oe;
    logic [3:0] loc_addr;
    logic       loc_we;
    logic [7:0] loc_wdata, loc_rdata;
    logic       wr_strobe;
    logic [3:0] wr_index;
    logic       busy;

    int         vectors = 0;
    int         fails   = 0;
    logic [7:0] model_regs [16];
    int         model_ptr;
    int         strobe_log [$];
    int         exp_log [$];
    logic       strobe_prev;
    logic       saw_oe, saw_busy;

    always #5 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_slave_regs dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .loc_addr  (loc_addr),
        .loc_we    (loc_we),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_log.push_back(int'(wr_index));
            check("strobe_width", 32'(strobe_prev === 1'b1), 32'd0);
        end
        strobe_prev = wr_strobe;
        if (sda_oe === 1'b1) saw_oe = 1'b1;
        if (busy === 1'b1) saw_busy = 1'b1;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        clks(5); sda_m = b; clks(5); scl_m = 1'b1; clks(9); r = sda_in; clks(1); scl_m = 1'b0;
    endtask

    task automatic start_cond();
        clks(5); sda_m = 1'b1; clks(5); scl_m = 1'b1; clks(10); sda_m = 1'b0; clks(10); scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        clks(5); sda_m = 1'b0; clks(5); scl_m = 1'b1; clks(10); sda_m = 1'b1; clks(10);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(master_ack, r);
    endtask

    task automatic loc_write(input int idx, input logic [7:0] d);
        loc_addr = 4'(idx); loc_wdata = d; loc_we = 1'b1; clks(1); loc_we = 1'b0;
        model_regs[idx] = d;
    endtask

    task automatic loc_read(input int idx, output logic [7:0] d);
        loc_addr = 4'(idx); loc_we = 1'b0; clks(1); d = loc_rdata;
    endtask

    task automatic check_all_regs(input string tag);
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            loc_read(i, d);
            check(tag, 32'(d), 32'(model_regs[i]));
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, 32'(strobe_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < strobe_log.size(); i++)
            check(tag, 32'(strobe_log[i]), 32'(exp_log[i]));
        strobe_log.delete();
        exp_log.delete();
    endtask

    initial begin
        logic       a;
        logic [7:0] d, v;
        logic [6:0] bad;
        int         p, n, got;
        logic [7:0] burst [4];

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        loc_addr = '0; loc_we = 1'b0; loc_wdata = '0;
        saw_oe = 1'b0; saw_busy = 1'b0; strobe_prev = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        clks(3);
        rst = 1'b0;
        clks(1);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_loc_rdata", 32'(loc_rdata), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_index", 32'(wr_index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_all_regs("rst_regs");

        // Write pointer 3, data 0x11 and 0x22.
        start_cond();
        write_byte(8'h54, a); check("w_addr_ack", 32'(a), 32'd0);
        check("w_busy", 32'(busy), 32'd1);
        write_byte(8'h03, a); check("w_ptr_ack", 32'(a), 32'd0);
        write_byte(8'h11, a); check("w_d0_ack", 32'(a), 32'd0);
        write_byte(8'h22, a); check("w_d1_ack", 32'(a), 32'd0);
        stop_cond();
        model_regs[3] = 8'h11; model_regs[4] = 8'h22; model_ptr = 5;
        exp_log.push_back(3); exp_log.push_back(4);
        check("w_busy_after_stop", 32'(busy), 32'd0);
        check("w_index_hold", 32'(wr_index), 32'd4);
        check_log("w_strobe");
        check_all_regs("w_regs");

        // Random fill, then pointer 0x0F, repeated START, 3-byte read wrapping.
        for (int i = 0; i < 16; i++) loc_write(i, 8'($urandom));
        start_cond();
        write_byte(8'h54, a); check("rd_addr_ack", 32'(a), 32'd0);
        write_byte(8'h0F, a); check("rd_ptr_ack", 32'(a), 32'd0);
        model_ptr = 15;
        start_cond();
        write_byte(8'h55, a); check("rd_raddr_ack", 32'(a), 32'd0);
        for (int k = 0; k < 3; k++) begin
            read_byte(k == 2, d);
            check("rd_wrap_data", 32'(d), 32'(model_regs[model_ptr]));
            model_ptr = (model_ptr + 1) % 16;
        end
        stop_cond();
        start_cond();
        write_byte(8'h55, a); check("rd_persist_ack", 32'(a), 32'd0);
        read_byte(1'b1, d);
        check("rd_persist_data", 32'(d), 32'(model_regs[model_ptr]));
        model_ptr = (model_ptr + 1) % 16;
        stop_cond();
        check_log("rd_no_strobe");

        // Mismatched addresses: 0x2B then a random one.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) bad = 7'h2B;
            else begin
                bad = 7'($urandom_range(0, 127));
                if (bad == 7'h2A) bad = 7'h15;
            end
            saw_oe = 1'b0; saw_busy = 1'b0;
            start_cond();
            write_byte({bad, 1'b0}, a); check("nm_addr_nack", 32'(a), 32'd1);
            write_byte(8'h02, a);       check("nm_ptr_nack", 32'(a), 32'd1);
            write_byte(8'($urandom), a); check("nm_data_nack", 32'(a), 32'd1);
            stop_cond();
            check("nm_sda_never", 32'(saw_oe), 32'd0);
            check("nm_busy_never", 32'(saw_busy), 32'd0);
        end
        check_log("nm_no_strobe");
        check_all_regs("nm_regs");

        // Local write of 0xCC to index 5 held through the I2C write of 0x55.
        start_cond();
        write_byte(8'h54, a); check("col_addr_ack", 32'(a), 32'd0);
        write_byte(8'h05, a); check("col_ptr_ack", 32'(a), 32'd0);
        d = 8'h55;
        for (int i = 7; i >= 1; i--) bus_bit(d[i], a);
        clks(5); sda_m = d[0]; clks(5);
        loc_addr = 4'd5; loc_wdata = 8'hCC; loc_we = 1'b1; scl_m = 1'b1;
        got = 0;
        for (int k = 0; k < 12 && got == 0; k++) begin
            clks(1);
            if (wr_strobe === 1'b1) got = 1;
        end
        loc_we = 1'b0;
        check("col_strobe_seen", 32'(got), 32'd1);
        clks(4); scl_m = 1'b0;
        bus_bit(1'b1, a); check("col_data_ack", 32'(a), 32'd0);
        stop_cond();
        model_regs[5] = 8'h55; model_ptr = 6; exp_log.push_back(5);
        check_log("col_strobe");
        loc_read(5, v);
        check("col_reg5", 32'(v), 32'h55);

        // Random bursts with upper pointer bits set, read back over I2C.
        for (int it = 0; it < 3; it++) begin
            p = int'($urandom_range(0, 15));
            n = int'($urandom_range(1, 4));
            start_cond();
            write_byte(8'h54, a); check("rnd_addr_ack", 32'(a), 32'd0);
            write_byte({4'($urandom), 4'(p)}, a); check("rnd_ptr_ack", 32'(a), 32'd0);
            for (int k = 0; k < n; k++) begin
                burst[k] = 8'($urandom);
                write_byte(burst[k], a); check("rnd_data_ack", 32'(a), 32'd0);
                model_regs[(p + k) % 16] = burst[k];
                exp_log.push_back((p + k) % 16);
            end
            stop_cond();
            check_log("rnd_strobe");
            start_cond();
            write_byte(8'h54, a);
            write_byte(8'(p), a);
            start_cond();
            write_byte(8'h55, a); check("rnd_raddr_ack", 32'(a), 32'd0);
            for (int k = 0; k < n; k++) begin
                read_byte(k == n - 1, d);
                check("rnd_read", 32'(d), 32'(model_regs[(p + k) % 16]));
            end
            stop_cond();
            model_ptr = (p + n) % 16;
        end

        // STOP in the middle of a data byte.
        p = int'($urandom_range(0, 15));
        start_cond();
        write_byte(8'h54, a); check("ms_addr_ack", 32'(a), 32'd0);
        write_byte(8'(p), a);  check("ms_ptr_ack", 32'(a), 32'd0);
        model_ptr = p;
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), a);
        stop_cond();
        check("ms_busy", 32'(busy), 32'd0);
        check_log("ms_no_strobe");
        start_cond();
        write_byte(8'h55, a); check("ms_raddr_ack", 32'(a), 32'd0);
        read_byte(1'b1, d);
        check("ms_reg_kept", 32'(d), 32'(model_regs[p]));
        stop_cond();

        // Reset while a 0 data bit is on the bus.
        p = int'($urandom_range(0, 15));
        loc_write(p, 8'h3C);
        start_cond();
        write_byte(8'h54, a);
        write_byte(8'(p), a);
        start_cond();
        write_byte(8'h55, a); check("rs_raddr_ack", 32'(a), 32'd0);
        clks(5); sda_m = 1'b1; clks(5); scl_m = 1'b1; clks(4);
        check("rs_driving_zero", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        clks(1);
        check("rs_sda_released", 32'(sda_oe), 32'd0);
        rst = 1'b0;
        clks(4); scl_m = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        start_cond();
        write_byte(8'h54, a); check("rs_addr_ack", 32'(a), 32'd0);
        check("rs_busy", 32'(busy), 32'd1);
        stop_cond();
        check_all_regs("rs_regs");
        check_log("rs_no_strobe");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
